basilisk_mult_exponent: RTL and testbench

- First pipeline stage of the basilisk FP multiply/MACC path.
- Accepts a decoded single-precision multiply command (a, b, optional addend c, round mode, MACC enable) and classifies operand specials.
- Computes the product sign and the biased product exponent, and expands both mantissas with their hidden bits.
- Registers the result, with a skid buffer, into the mantissa-multiply stage downstream; the addend c passes through untouched for the later add/normalize stage.

---
 rtl/basilisk_mult_exponent.sv | 137 +++++++++++++
 tb/tb_basilisk_mult_exponent.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/basilisk_mult_exponent.sv
// First stage of the basilisk FP multiply/MACC path: operand classification,
// product sign/exponent, hidden-bit mantissa expansion, registered with a skid buffer.
module basilisk_mult_exponent #(
  parameter int BIAS        = 127,
  parameter bit ENABLE_SKID = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_enable_macc,
  input  logic [2:0]  in_mode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_enable_macc,
  output logic [2:0]  out_mode,
  output logic [31:0] out_c,
  output logic        out_sign,
  output logic [9:0]  out_exp,
  output logic [23:0] out_mant_a,
  output logic [23:0] out_mant_b,
  output logic        out_nan,
  output logic        out_inf,
  output logic        out_zero
);

  typedef struct packed {
    logic        enable_macc;
    logic [2:0]  mode;
    logic [31:0] c;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        nan;
    logic        inf;
    logic        zero;
  } payload_t;

  payload_t    in_pl;
  payload_t    out_q;
  payload_t    skid_q;
  logic        out_valid_q;
  logic        skid_full;
  logic        in_ready_q;
  logic        run_q;
  logic        in_fire;
  logic        out_load;

  logic [7:0]  exp_a, exp_b, e_eff_a, e_eff_b;
  logic [22:0] man_a, man_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        p_nan, p_inf;

  always_comb begin
    exp_a   = in_a[30:23];
    exp_b   = in_b[30:23];
    man_a   = in_a[22:0];
    man_b   = in_b[22:0];
    // Denormals use an effective exponent of 1 with no hidden bit.
    e_eff_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
    e_eff_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
    nan_a   = (exp_a == 8'hFF) && (man_a != '0);
    nan_b   = (exp_b == 8'hFF) && (man_b != '0);
    inf_a   = (exp_a == 8'hFF) && (man_a == '0);
    inf_b   = (exp_b == 8'hFF) && (man_b == '0);
    zero_a  = (exp_a == 8'd0) && (man_a == '0);
    zero_b  = (exp_b == 8'd0) && (man_b == '0);
    p_nan   = nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b);
    p_inf   = (inf_a || inf_b) && !p_nan;

    in_pl             = '0;
    in_pl.enable_macc = in_enable_macc;
    in_pl.mode        = in_mode;
    in_pl.c           = in_c;
    in_pl.sign        = (in_a[31] ^ in_b[31]) && !p_nan;
    in_pl.exp         = {2'b00, e_eff_a} + {2'b00, e_eff_b} - 10'(BIAS);
    in_pl.mant_a      = {exp_a != 8'd0, man_a};
    in_pl.mant_b      = {exp_b != 8'd0, man_b};
    in_pl.nan         = p_nan;
    in_pl.inf         = p_inf;
    in_pl.zero        = (zero_a || zero_b) && !p_nan && !p_inf;
  end

  assign out_load = !out_valid_q || out_ready;
  assign in_ready = ENABLE_SKID ? in_ready_q : (run_q && out_load);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
      in_ready_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (out_load) begin
        // Skid always empties here, so ready can reassert next cycle.
        in_ready_q <= 1'b1;
        if (skid_full) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
          skid_full   <= 1'b0;
        end else if (in_fire) begin
          out_q       <= in_pl;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else begin
        in_ready_q <= !(skid_full || in_fire);
        if (in_fire) begin
          skid_q    <= in_pl;
          skid_full <= 1'b1;
        end
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_enable_macc = out_q.enable_macc;
  assign out_mode        = out_q.mode;
  assign out_c           = out_q.c;
  assign out_sign        = out_q.sign;
  assign out_exp         = out_q.exp;
  assign out_mant_a      = out_q.mant_a;
  assign out_mant_b      = out_q.mant_b;
  assign out_nan         = out_q.nan;
  assign out_inf         = out_q.inf;
  assign out_zero        = out_q.zero;

endmodule

// File: tb/tb_basilisk_mult_exponent.sv
// Bench for basilisk_mult_exponent: directed cases from the test plan plus
// randomized traffic and backpressure checked against a queue-based reference model.
module tb_basilisk_mult_exponent;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_enable_macc;
  logic [2:0]  in_mode;
  logic [31:0] in_a, in_b, in_c;
  logic        out_valid;
  logic        out_ready;
  logic        out_enable_macc;
  logic [2:0]  out_mode;
  logic [31:0] out_c;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_mant_a, out_mant_b;
  logic        out_nan, out_inf, out_zero;

  logic [97:0] out_bus;
  logic [97:0] exp_q[$];
  logic [97:0] held_bus;
  logic        held;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  basilisk_mult_exponent #(.BIAS(127), .ENABLE_SKID(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_enable_macc(in_enable_macc), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_enable_macc(out_enable_macc), .out_mode(out_mode), .out_c(out_c),
    .out_sign(out_sign), .out_exp(out_exp),
    .out_mant_a(out_mant_a), .out_mant_b(out_mant_b),
    .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero)
  );

  assign out_bus = {out_enable_macc, out_mode, out_c, out_sign, out_exp,
                    out_mant_a, out_mant_b, out_nan, out_inf, out_zero};

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: IEEE single special rules and plain integer exponent arithmetic.
  function automatic logic [97:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic macc,
                                        input logic [2:0] mode);
    int ea, eb, ma, mb, sum;
    bit na, nb, ia, ib, za, zb, nan, inf, zero, sign;
    logic [9:0]  e10;
    logic [23:0] m24a, m24b;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = int'(a[22:0]);
    mb = int'(b[22:0]);
    na = (ea == 255) && (ma != 0);
    nb = (eb == 255) && (mb != 0);
    ia = (ea == 255) && (ma == 0);
    ib = (eb == 255) && (mb == 0);
    za = (ea == 0) && (ma == 0);
    zb = (eb == 0) && (mb == 0);
    nan  = na || nb || (ia && zb) || (za && ib);
    inf  = (ia || ib) && !nan;
    zero = (za || zb) && !nan && !inf;
    sign = nan ? 1'b0 : (a[31] ^ b[31]);
    sum  = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
    e10  = sum[9:0];
    m24a = 24'(((ea != 0) ? 32'h0080_0000 : 0) + ma);
    m24b = 24'(((eb != 0) ? 32'h0080_0000 : 0) + mb);
    return {macc, mode, c, sign, e10, m24a, m24b, nan, inf, zero};
  endfunction

  // Scoreboard: samples handshakes on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held && out_valid) chk("hold_stable", out_bus, held_bus);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("result", out_bus, exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a, in_b, in_c, in_enable_macc, in_mode));
      held     = out_valid && !out_ready;
      held_bus = out_bus;
    end
  end

  task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic macc, input logic [2:0] mode);
    in_a = a; in_b = b; in_c = c; in_enable_macc = macc; in_mode = mode;
    in_valid = 1'b1;
  endtask

  // Presents a command and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic macc, input logic [2:0] mode);
    bit ok;
    ok = 1'b0;
    set_cmd(a, b, c, macc, mode);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 5))
      0: e = 8'd0;
      1: e = 8'd255;
      default: e = 8'($urandom);
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  initial begin
    bit fire;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_enable_macc = 1'b0; in_mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_bus, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    send(32'h3FC0_0000, 32'h4000_0000, 32'h0, 1'b0, 3'd0);
    chk("m15_valid", out_valid, 1);
    chk("m15_sign", out_sign, 0);
    chk("m15_exp", out_exp, 10'd128);
    chk("m15_mant_a", out_mant_a, 24'hC00000);
    chk("m15_mant_b", out_mant_b, 24'h800000);
    chk("m15_flags", {out_nan, out_inf, out_zero}, 3'b000);

    send(32'h8000_0001, 32'h3F80_0000, 32'h0, 1'b0, 3'd0);
    chk("den_exp", out_exp, 10'd1);
    chk("den_mant_a", out_mant_a, 24'h000001);
    chk("den_mant_b", out_mant_b, 24'h800000);
    chk("den_sign", out_sign, 1);
    chk("den_flags", {out_nan, out_inf, out_zero}, 3'b000);

    send(32'h7F80_0000, 32'h0000_0000, 32'h0, 1'b0, 3'd0);
    chk("inf_x_zero", {out_nan, out_sign}, 2'b10);
    send(32'hFF80_0000, 32'h3F80_0000, 32'h0, 1'b0, 3'd0);
    chk("neg_inf", {out_inf, out_sign, out_nan}, 3'b110);
    send(32'h7FC0_0000, 32'h7F80_0000, 32'h0, 1'b0, 3'd0);
    chk("nan_x_inf", out_nan, 1);

    send(32'h4040_0000, 32'h3F00_0000, 32'hC049_0FDB, 1'b1, 3'b010);
    chk("pass_macc", out_enable_macc, 1);
    chk("pass_mode", out_mode, 3'b010);
    chk("pass_c", out_c, 32'hC049_0FDB);

    // Backpressure: cmd0 to output, cmd1 to skid, cmd2 held off.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h3F80_0000, 32'h4000_0000, 32'h1111_1111, 1'b0, 3'd1);
    send(32'h4080_0000, 32'h4100_0000, 32'h2222_2222, 1'b1, 3'd2);
    set_cmd(32'hC000_0000, 32'h4040_0000, 32'h3333_3333, 1'b0, 3'd3);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'hC000_0000, 32'h4040_0000, 32'h3333_3333, 1'b0, 3'd3);
    @(posedge clk); #1;
    chk("bp_drained", exp_q.size(), 0);

    // Reset with output and skid both occupied.
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h3F80_0000, 32'h4444_4444, 1'b0, 3'd4);
    send(32'h4000_0000, 32'h4000_0000, 32'h5555_5555, 1'b0, 3'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 0);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready_back", in_ready, 1);
    send(32'h4110_0000, 32'hBF80_0000, 32'h6666_6666, 1'b1, 3'd6);
    chk("rst_next_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("rst_next_alone", out_valid, 0);

    // Randomized traffic with random backpressure; commands hold until accepted.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || fire) begin
        if ($urandom_range(0, 9) < 7)
          set_cmd(rand_op(), rand_op(), $urandom, 1'($urandom), 3'($urandom));
        else
          in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("final_drain", exp_q.size(), 0);
    chk("final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
